// File: rtl/regwr_pkg.sv
// rtl/regwr_pkg.sv - shared types and default constants for the register-file write arbiter
// Contents: write-request struct, arbiter FSM state enum, width and default-parameter constants,
// and a helper that recognises writes to the hard-wired zero register.
package regwr_pkg;

    localparam int ADDR_W           = 5;
    localparam int DATA_W           = 32;
    localparam int REQ_W            = ADDR_W + DATA_W;
    localparam int DEF_FIFO_DEPTH   = 2;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_t;

    // Register 0 is hard-wired, so writes to it are dropped everywhere.
    function automatic logic is_reg_zero(input logic [ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regwr_fifo.sv
// rtl/regwr_fifo.sv - FIFO of queued port-B register writes
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes all entries)
//   i_push          enqueue i_push_data (ignored when full)
//   i_push_data     wr_req_t packed as {addr, data}
//   i_pop           dequeue the head (ignored when empty)
//   o_head          current head entry, valid when o_empty=0
//   o_full, o_empty occupancy flags from registered state only
//   o_vld, o_addrs  per-slot valid bits and addresses for the pending-write check
module regwr_fifo
    import regwr_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [REQ_W-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [REQ_W-1:0]             o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [FIFO_DEPTH-1:0]        o_vld,
    output logic [FIFO_DEPTH*ADDR_W-1:0] o_addrs
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    wr_req_t               r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_vld;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  w_do_push;
    logic                  w_do_pop;

    // Wrap explicitly so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Occupancy is tracked as a per-slot valid vector; this doubles as the
    // entry-valid view needed by the pending-write compare.
    assign o_full    = &r_vld;
    assign o_empty   = ~|r_vld;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_vld     = r_vld;

    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_addr
        assign o_addrs[g*ADDR_W +: ADDR_W] = r_mem[g].addr;
    end

    // Pointers only coincide when empty or full, so a simultaneous push and
    // pop never touch the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_req_t'(i_push_data);
        end
    end

endmodule

// File: rtl/regwr_arbiter.sv
// rtl/regwr_arbiter.sv - two-port register-file write arbiter with starvation guard
// Optional feature macro: REGWR_PENDING_CHECK_EN (pending-write address compare).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_valid, a_waddr, a_wdata      pipeline write-back request (priority port)
//   a_stall                        A not accepted this cycle (forced B slot)
//   b_valid, b_waddr, b_wdata      long-latency unit write request, queued
//   b_ready                        B queue can accept this cycle
//   we, waddr, wdata               registered register-file write port
//   chk_addr1/2, chk_hit1/2        query whether an address has a queued B write
module regwr_arbiter
    import regwr_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_waddr,
    input  logic [31:0] a_wdata,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_waddr,
    input  logic [31:0] b_wdata,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_hit1,
    output logic        chk_hit2
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t                   r_state;
    arb_state_t                   w_state_nxt;
    logic [CNT_W-1:0]             r_starve_cnt;
    logic [CNT_W-1:0]             w_starve_nxt;
    logic                         r_we;
    logic [4:0]                   r_waddr;
    logic [31:0]                  r_wdata;
    logic                         w_grant_a;
    logic                         w_grant_b;
    logic                         w_stall;
    logic                         w_push;
    logic                         w_full;
    logic                         w_empty;
    logic [REQ_W-1:0]             w_head_raw;
    wr_req_t                      w_head;
    logic [FIFO_DEPTH-1:0]        w_fifo_vld;
    logic [FIFO_DEPTH*ADDR_W-1:0] w_fifo_addrs;

    // Zero-register pushes complete the handshake but are never stored.
    assign b_ready = !rst && !w_full;
    assign w_push  = b_valid && b_ready && !is_reg_zero(b_waddr);
    assign w_head  = wr_req_t'(w_head_raw);

    regwr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({b_waddr, b_wdata}),
        .i_pop       (w_grant_b),
        .o_head      (w_head_raw),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_vld       (w_fifo_vld),
        .o_addrs     (w_fifo_addrs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_NORMAL;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // FIFO emptiness comes from registered state, so an entry pushed this
    // cycle cannot be granted until the next one.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_grant_a    = 1'b0;
        w_grant_b    = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (a_valid) begin
                    w_grant_a = 1'b1;
                end else if (!w_empty) begin
                    w_grant_b = 1'b1;
                end
                if (!w_empty && !w_grant_b) begin
                    if (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                        w_state_nxt  = ST_FORCE;
                        w_starve_nxt = '0;
                    end else begin
                        w_starve_nxt = r_starve_cnt + 1'b1;
                    end
                end else begin
                    w_starve_nxt = '0;
                end
            end
            ST_FORCE: begin
                // One-cycle B slot: stall A and drain the head regardless.
                w_stall      = 1'b1;
                w_grant_b    = !w_empty;
                w_state_nxt  = ST_NORMAL;
                w_starve_nxt = '0;
            end
            default: begin
                w_state_nxt  = ST_NORMAL;
                w_starve_nxt = '0;
            end
        endcase
    end

    assign a_stall = !rst && w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_grant_a) begin
            r_we    <= !is_reg_zero(a_waddr);
            r_waddr <= a_waddr;
            r_wdata <= a_wdata;
        end else if (w_grant_b) begin
            r_we    <= 1'b1;
            r_waddr <= w_head.addr;
            r_wdata <= w_head.data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign we    = r_we;
    assign waddr = r_waddr;
    assign wdata = r_wdata;

`ifdef REGWR_PENDING_CHECK_EN
    logic w_hit1;
    logic w_hit2;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_fifo_vld[i] && (w_fifo_addrs[i*ADDR_W +: ADDR_W] == chk_addr1)) begin
                w_hit1 = 1'b1;
            end
            if (w_fifo_vld[i] && (w_fifo_addrs[i*ADDR_W +: ADDR_W] == chk_addr2)) begin
                w_hit2 = 1'b1;
            end
        end
    end

    assign chk_hit1 = !rst && !is_reg_zero(chk_addr1) && w_hit1;
    assign chk_hit2 = !rst && !is_reg_zero(chk_addr2) && w_hit2;
`else
    logic w_unused_chk;

    assign w_unused_chk = ^{chk_addr1, chk_addr2, w_fifo_vld, w_fifo_addrs};
    assign chk_hit1     = 1'b0;
    assign chk_hit2     = 1'b0;
`endif

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of queued port-B writes.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the count of consecutive denied cycles that forces a B grant.
REQ-003 SHALL use clock clk and reset rst; rst is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_valid  in  1  pipeline write-back request
- a_waddr  in  5  port-A destination register
- a_wdata  in  32  port-A write data
- a_stall  out  1  A not accepted this cycle
- b_valid  in  1  long-latency unit write request
- b_ready  out  1  port-B FIFO can accept
- b_waddr  in  5  port-B destination register
- b_wdata  in  32  port-B write data
- we  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata  out  32  register-file write data
- chk_addr1  in  5  pending-write query 1
- chk_addr2  in  5  pending-write query 2
- chk_hit1  out  1  chk_addr1 has a queued B write
- chk_hit2  out  1  chk_addr2 has a queued B write

Function
REQ-005 SHALL register we, waddr and wdata; a grant in cycle t appears on these outputs in cycle t+1, for exactly one cycle.
REQ-006 SHALL accept A in cycle t when a_valid=1 and a_stall=0.
REQ-007 SHALL, when an accepted A request has a_waddr=0, consume the request while we stays 0 in t+1.
REQ-008 SHALL drive b_ready = !full; a B push occurs at the edge when b_valid && b_ready.
REQ-009 SHALL, for a B push with b_waddr=0, complete the handshake but store nothing.
REQ-010 SHALL not bypass a pushed B entry; it becomes eligible at the FIFO head no earlier than the cycle after its push.
REQ-011 SHALL run a 2-state FSM with states NORMAL and FORCE.
REQ-012 SHALL, in NORMAL, grant A whenever a_valid=1 (a_stall=0), otherwise grant the FIFO head if the FIFO is non-empty.
REQ-013 SHALL, in NORMAL, increment starve_cnt when the FIFO is non-empty and the head is not granted, and clear it when the head is granted or the FIFO is empty.
REQ-014 SHALL, when starve_cnt would reach STARVE_LIMIT, transition NORMAL->FORCE and clear starve_cnt.
REQ-015 SHALL, in FORCE, drive a_stall=1, grant the FIFO head, and return to NORMAL unconditionally on the next edge.
REQ-016 SHALL drive a_stall=0 in NORMAL.
REQ-017 SHALL allow a push and a pop in the same cycle; occupancy is unchanged in that case.
REQ-018 SHALL, when the FIFO is full, hold b_ready=0 even if a pop occurs that cycle.
REQ-019 SHALL preserve B write order (FIFO).

Reset
REQ-020 SHALL, while rst=1, hold we=0, waddr=0, wdata=0, a_stall=0, b_ready=0, chk_hit1/2=0.
REQ-021 SHALL, while rst=1, set state NORMAL, starve_cnt=0, and flush the FIFO (pending entries are discarded, including on reset mid-operation).
REQ-022 SHALL make b_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-023 SHALL honour macro REGWR_PENDING_CHECK_EN.
REQ-024 SHALL, when REGWR_PENDING_CHECK_EN is defined, set chk_hitN=1 iff chk_addrN!=0 and any valid FIFO entry matches chk_addrN; this is combinational with same-cycle visibility of FIFO contents.
REQ-025 SHALL, when REGWR_PENDING_CHECK_EN is undefined, tie chk_hit1/2 to 0 with no compare logic.

Structure
REQ-026 SHALL place wr_req_t (addr 5b, data 32b), the FSM state enum and default parameter constants in shared package regwr_pkg.
REQ-027 SHALL implement the queue as sub-module regwr_fifo (depth FIFO_DEPTH, push/pop/full/empty, entry visibility for pending check).

Verification
REQ-028 SHALL cover: A only, a_valid=1, a_waddr=3, a_wdata=0x11 at t -> we=1, waddr=3, wdata=0x11 at t+1; a_stall=0.
REQ-029 SHALL cover: B only, push (7, 0xAA) at t with A idle -> we=1, waddr=7, wdata=0xAA at t+2.
REQ-030 SHALL cover: starvation, a_valid=1 continuously and one B entry queued, STARVE_LIMIT=4 -> a_stall=1 for one cycle after 4 denied cycles, B write appears next cycle, then A resumes.
REQ-031 SHALL cover: full FIFO, two B pushes while A is continuously busy -> b_ready=0; a third b_valid is not accepted until a pop.
REQ-032 SHALL cover: zero address, a_waddr=0 and a B push to 0 -> we never asserts; FIFO stays empty.
REQ-033 SHALL cover: reset mid-operation, rst=1 with 2 entries queued -> FIFO empty and we=0; after release, b_ready=1 and no stale write occurs; with REGWR_PENDING_CHECK_EN, chk_addr1=7 and entry 7 queued -> chk_hit1=1, and chk_hit1=0 after its pop.
